// File: rtl/dp_pixel_scaler.sv
// Per-channel pixel datapath: bypass, 2^k averaging downscale and 2^k replication upscale.
// Define DPA_SCALE_ROUND_EN to round averages half up (saturating) instead of truncating.
module dp_pixel_scaler #(
    parameter int NCH    = 3,
    parameter int CW     = 8,
    parameter int MAXLOG = 2,
    parameter int CNTW   = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [1:0]          mode,
    input  logic [2:0]          ratio_log,
    input  logic                flush,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [NCH*CW-1:0]   in_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [NCH*CW-1:0]   out_data,
    output logic                busy,
    output logic [CNTW-1:0]     pix_cnt
);
    localparam int AW  = CW + MAXLOG;
    localparam int AW1 = AW + 1;
    localparam int CTW = MAXLOG + 1;
    localparam logic [1:0] M_BYP = 2'b00;
    localparam logic [1:0] M_AVG = 2'b01;
    localparam logic [1:0] M_EXP = 2'b10;

    typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_REPL} state_t;

    state_t              r_state, w_state_next;
    logic [2:0]          r_k;
    logic [CTW-1:0]      r_cnt, r_rep;
    logic [NCH*CW-1:0]   r_hold, r_out_data;
    logic                r_out_valid;
    logic [CNTW-1:0]     r_pix_cnt;
    logic [AW-1:0]       r_acc [NCH];

    logic                w_ld_ok, w_accept, w_out_hs;
    logic [2:0]          w_k_in;
    logic [1:0]          w_eff_mode;
    logic [CTW-1:0]      w_r;
    logic                w_cnt_last, w_rep_last;
    logic                w_group_done, w_flush_emit, w_emit_avg;
    logic                w_load;
    logic [NCH*CW-1:0]   w_load_data, w_avg_pix;

    assign w_ld_ok   = !r_out_valid || out_ready;
    assign w_accept  = in_valid && in_ready;
    assign w_out_hs  = r_out_valid && out_ready;
    assign w_k_in    = (ratio_log > 3'(MAXLOG)) ? 3'(MAXLOG) : ratio_log;
    assign w_r       = CTW'(1) << r_k;
    assign w_cnt_last = (r_cnt == w_r - CTW'(1));
    assign w_rep_last = (r_rep == w_r);

    // A zero ratio or the reserved mode degenerates to a plain pass-through.
    always_comb begin
        w_eff_mode = M_BYP;
        if (w_k_in != 3'd0 && (mode == M_AVG || mode == M_EXP))
            w_eff_mode = mode;
    end

    assign w_group_done = (r_state == S_ACCUM) && w_accept && w_cnt_last;
    assign w_flush_emit = (r_state == S_ACCUM) && flush && w_ld_ok && !w_group_done;
    assign w_emit_avg   = w_group_done || w_flush_emit;

    genvar gi;
    generate
        for (gi = 0; gi < NCH; gi++) begin : g_ch
            logic [CW-1:0] w_in_ch;
            logic [AW-1:0] w_sum;
            assign w_in_ch = in_data[gi*CW +: CW];
            assign w_sum   = r_acc[gi] + {{MAXLOG{1'b0}}, (w_accept ? w_in_ch : {CW{1'b0}})};
`ifdef DPA_SCALE_ROUND_EN
            logic [AW:0] w_half, w_rsum, w_rsh;
            assign w_half = (r_k == 3'd0) ? '0 : (AW1'(1) << (r_k - 3'd1));
            assign w_rsum = {1'b0, w_sum} + w_half;
            assign w_rsh  = w_rsum >> r_k;
            assign w_avg_pix[gi*CW +: CW] = (|w_rsh[AW:CW]) ? {CW{1'b1}} : w_rsh[CW-1:0];
`else
            assign w_avg_pix[gi*CW +: CW] = CW'(w_sum >> r_k);
`endif
            always_ff @(posedge clk) begin
                if (!reset)
                    r_acc[gi] <= '0;
                else if (r_state == S_IDLE && w_accept && w_eff_mode == M_AVG)
                    r_acc[gi] <= {{MAXLOG{1'b0}}, w_in_ch};
                else if (w_emit_avg)
                    r_acc[gi] <= '0;
                else if (r_state == S_ACCUM && w_accept)
                    r_acc[gi] <= w_sum;
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!reset)
            r_state <= S_IDLE;
        else
            r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept && w_eff_mode == M_AVG) w_state_next = S_ACCUM;
                else if (w_accept && w_eff_mode == M_EXP) w_state_next = S_REPL;
            end
            S_ACCUM: if (w_emit_avg) w_state_next = S_IDLE;
            S_REPL:  if (w_out_hs && w_rep_last) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready = 1'b0;
        case (r_state)
            S_IDLE:  in_ready = w_ld_ok;
            S_ACCUM: in_ready = !w_cnt_last || w_ld_ok;
            default: in_ready = 1'b0;
        endcase
        if (!reset) in_ready = 1'b0;
        busy = (r_state != S_IDLE);
    end

    always_comb begin
        w_load      = 1'b0;
        w_load_data = in_data;
        case (r_state)
            S_IDLE:  w_load = w_accept && (w_eff_mode != M_AVG);
            S_ACCUM: begin
                w_load      = w_emit_avg;
                w_load_data = w_avg_pix;
            end
            S_REPL: begin
                w_load      = w_out_hs && !w_rep_last;
                w_load_data = r_hold;
            end
            default: w_load = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_pix_cnt   <= '0;
            r_k         <= '0;
            r_cnt       <= '0;
            r_rep       <= '0;
            r_hold      <= '0;
        end else begin
            if (w_out_hs)
                r_pix_cnt <= r_pix_cnt + CNTW'(1);
            if (w_load) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_load_data;
            end else if (w_out_hs) begin
                r_out_valid <= 1'b0;
            end
            // Ratio is frozen at group start so mid-group config changes wait for the next group.
            if (r_state == S_IDLE && w_accept) begin
                r_k    <= w_k_in;
                r_cnt  <= CTW'(1);
                r_rep  <= CTW'(1);
                r_hold <= in_data;
            end else begin
                if (r_state == S_ACCUM && w_accept)
                    r_cnt <= r_cnt + CTW'(1);
                if (r_state == S_REPL && w_out_hs && !w_rep_last)
                    r_rep <= r_rep + CTW'(1);
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign pix_cnt   = r_pix_cnt;
endmodule
